uart_rx_frontend: RTL

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

---
 rtl/uart_rx_frontend.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_frontend.sv
`timescale 1ns/1ps
// UART 8N1 receive front end: rxd synchronizer, mid-bit sampling FSM and a
// single-byte holding register with one-cycle frame/overrun error pulses.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_enable,
  input  logic       rx_ready,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    sync_reg;
  logic          rxs;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          byte_done, stop_low;
  logic [7:0]    data_reg;
  logic          valid_reg, frame_err_reg, overrun_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], rxd};
  end

  assign rxs = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_done  = 1'b0;
    stop_low   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_enable && !rxs) begin
          state_next = START;
          baud_next  = '0;
        end
      end
      START: begin
        // Half a bit in: a line still low is a genuine start bit.
        if (!rx_enable) begin
          state_next = IDLE;
        end else if (baud_reg == HALF_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (!rx_enable) begin
          state_next = IDLE;
        end else if (baud_reg == FULL_LAST) begin
          baud_next           = '0;
          shift_next[bit_reg] = rxs;
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      STOP: begin
        if (!rx_enable) begin
          state_next = IDLE;
        end else if (baud_reg == FULL_LAST) begin
          baud_next = '0;
          if (rxs) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_low   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      BREAK: begin
        if (!rx_enable || rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register: a completing byte wins over a simultaneous release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg        <= 8'h00;
      valid_reg       <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      frame_err_reg   <= stop_low;
      overrun_err_reg <= 1'b0;
      if (byte_done) begin
        if (!valid_reg || rx_ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_err_reg <= 1'b1;
        end
      end else if (valid_reg && rx_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data_out = data_reg;
  assign rx_valid    = valid_reg;
  assign rx_busy     = (state_reg != IDLE);
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_err_reg;

endmodule
